// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches car/hall calls, picks the next floor (collective control), times the door dwell.
// Optional FIRE_RECALL_EN adds a fire_recall input that forces the car to floor 0 and holds it there.
module elevator_request_scheduler #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef FIRE_RECALL_EN
  input  logic       fire_recall,
`endif
  input  logic [7:0] car_call,
  input  logic [7:0] hall_call,
  input  logic [2:0] current_floor,
  output logic [2:0] target_floor,
  output logic       target_valid,
  output logic [1:0] direction,
  output logic [7:0] pending,
  output logic       arrive
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DWELL} state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

  state_t     state_q;
  logic [7:0] pending_q;
  logic [2:0] target_q;
  logic       target_valid_q;
  logic [1:0] dir_q;
  logic [1:0] last_dir_q;
  logic       arrive_q;
  logic [7:0] dwell_cnt_q;
`ifdef FIRE_RECALL_EN
  logic       recall_q;
`endif

  logic [7:0] cf_mask;
  logic [7:0] req_in;
  logic [7:0] req_eff;
  logic [7:0] pending_d;
  logic       up_found;
  logic       dn_found;
  logic [2:0] up_floor;
  logic [2:0] dn_floor;
  logic [2:0] up_dist;
  logic [2:0] dn_dist;

  always_comb begin
    cf_mask  = 8'b1 << current_floor;
    req_in   = car_call | hall_call;
    // While the doors are open at this floor, a fresh call for it is absorbed.
    req_eff  = (state_q == DWELL) ? (req_in & ~cf_mask) : req_in;
`ifdef FIRE_RECALL_EN
    if (fire_recall) req_eff = 8'h00;
`endif
    pending_d = pending_q | req_eff;
    up_found = 1'b0;
    up_floor = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i] && (3'(i) > current_floor)) begin
        up_found = 1'b1;
        up_floor = 3'(i);
      end
    end
    dn_found = 1'b0;
    dn_floor = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i] && (3'(i) < current_floor)) begin
        dn_found = 1'b1;
        dn_floor = 3'(i);
      end
    end
    up_dist = up_floor - current_floor;
    dn_dist = current_floor - dn_floor;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pending_q      <= 8'h00;
      target_q       <= 3'd0;
      target_valid_q <= 1'b0;
      dir_q          <= DIR_IDLE;
      last_dir_q     <= DIR_IDLE;
      arrive_q       <= 1'b0;
      dwell_cnt_q    <= 8'd0;
`ifdef FIRE_RECALL_EN
      recall_q       <= 1'b0;
`endif
    end else begin
      arrive_q  <= 1'b0;
      pending_q <= pending_d;
`ifdef FIRE_RECALL_EN
      if (fire_recall) begin
        recall_q    <= 1'b1;
        pending_q   <= 8'h00;
        target_q    <= 3'd0;
        last_dir_q  <= DIR_IDLE;
        dwell_cnt_q <= 8'd0;
        if (current_floor == 3'd0) begin
          if (state_q != DWELL) arrive_q <= 1'b1;
          state_q        <= DWELL;
          target_valid_q <= 1'b0;
          dir_q          <= DIR_IDLE;
        end else begin
          state_q        <= MOVE_DOWN;
          target_valid_q <= 1'b1;
          dir_q          <= DIR_DN;
        end
      end else if (recall_q) begin
        recall_q       <= 1'b0;
        state_q        <= IDLE;
        target_q       <= current_floor;
        target_valid_q <= 1'b0;
        dir_q          <= DIR_IDLE;
      end else
`endif
      begin
        case (state_q)
          IDLE: begin
            target_q       <= current_floor;
            target_valid_q <= 1'b0;
            dir_q          <= DIR_IDLE;
            if (pending_q[current_floor]) begin
              state_q     <= DWELL;
              arrive_q    <= 1'b1;
              pending_q   <= pending_d & ~cf_mask;
              dwell_cnt_q <= 8'd0;
              last_dir_q  <= DIR_IDLE;
            end else if (up_found && (!dn_found || (up_dist <= dn_dist))) begin
              state_q        <= MOVE_UP;
              target_q       <= up_floor;
              target_valid_q <= 1'b1;
              dir_q          <= DIR_UP;
            end else if (dn_found) begin
              state_q        <= MOVE_DOWN;
              target_q       <= dn_floor;
              target_valid_q <= 1'b1;
              dir_q          <= DIR_DN;
            end
          end

          MOVE_UP, MOVE_DOWN: begin
            if (current_floor == target_q) begin
              state_q        <= DWELL;
              arrive_q       <= 1'b1;
              pending_q      <= pending_d & ~cf_mask;
              dwell_cnt_q    <= 8'd0;
              last_dir_q     <= dir_q;
              target_valid_q <= 1'b0;
              dir_q          <= DIR_IDLE;
            end else if ((state_q == MOVE_UP) ? up_found : !dn_found && up_found) begin
              state_q        <= MOVE_UP;
              target_q       <= up_floor;
              dir_q          <= DIR_UP;
            end else if (dn_found) begin
              state_q        <= MOVE_DOWN;
              target_q       <= dn_floor;
              dir_q          <= DIR_DN;
            end else begin
              state_q        <= IDLE;
              target_q       <= current_floor;
              target_valid_q <= 1'b0;
              dir_q          <= DIR_IDLE;
            end
          end

          DWELL: begin
            target_q <= current_floor;
            if (|(req_in & cf_mask)) begin
              dwell_cnt_q <= 8'd0;
            end else if (dwell_cnt_q >= DWELL_LAST) begin
              dwell_cnt_q <= 8'd0;
              // Keep the prior heading while calls remain ahead, otherwise turn around.
              if ((last_dir_q == DIR_UP && up_found) ||
                  (last_dir_q == DIR_DN && !dn_found && up_found)) begin
                state_q        <= MOVE_UP;
                target_q       <= up_floor;
                target_valid_q <= 1'b1;
                dir_q          <= DIR_UP;
              end else if ((last_dir_q != DIR_IDLE) && dn_found) begin
                state_q        <= MOVE_DOWN;
                target_q       <= dn_floor;
                target_valid_q <= 1'b1;
                dir_q          <= DIR_DN;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              dwell_cnt_q <= dwell_cnt_q + 8'd1;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign target_floor = target_q;
  assign target_valid = target_valid_q;
  assign direction    = dir_q;
  assign pending      = pending_q;
  assign arrive       = arrive_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler: reset, single trip, collection, reversal, tie and dwell restart.
module tb_elevator_request_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] car_call;
  logic [7:0] hall_call;
  logic [2:0] current_floor;
  logic [2:0] target_floor;
  logic       target_valid;
  logic [1:0] direction;
  logic [7:0] pending;
  logic       arrive;
`ifdef FIRE_RECALL_EN
  logic       fire_recall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  elevator_request_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIRE_RECALL_EN
    .fire_recall  (fire_recall),
`endif
    .car_call     (car_call),
    .hall_call    (hall_call),
    .current_floor(current_floor),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .direction    (direction),
    .pending      (pending),
    .arrive       (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] floor);
    rst = 1'b0;
    car_call = 8'h00;
    hall_call = 8'h00;
    current_floor = floor;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    car_call = 8'hFF;
    hall_call = 8'hFF;
    current_floor = 3'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending cyc%0d got=%h exp=00", i, pending); end
      n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL reset_dir cyc%0d got=%b exp=00", i, direction); end
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid cyc%0d got=%b exp=0", i, target_valid); end
      n_cmp++; if (target_floor !== 3'd0) begin n_bad++; $display("FAIL reset_target cyc%0d got=%0d exp=0", i, target_floor); end
      n_cmp++; if (arrive !== 1'b0) begin n_bad++; $display("FAIL reset_arrive cyc%0d got=%b exp=0", i, arrive); end
    end
    car_call = 8'h00;
    hall_call = 8'h00;
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_up();
    do_reset(3'd0);
    car_call = 8'h08;
    tick();
    car_call = 8'h00;
    n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL up_latch got=%h exp=08", pending); end
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL up_still_idle got=%b exp=00", direction); end
    tick();
    n_cmp++; if (direction !== 2'b01) begin n_bad++; $display("FAIL up_dir got=%b exp=01", direction); end
    n_cmp++; if (target_floor !== 3'd3) begin n_bad++; $display("FAIL up_target got=%0d exp=3", target_floor); end
    n_cmp++; if (target_valid !== 1'b1) begin n_bad++; $display("FAIL up_tvalid got=%b exp=1", target_valid); end
    current_floor = 3'd1;
    tick();
    n_cmp++; if (target_floor !== 3'd3) begin n_bad++; $display("FAIL up_target_hold got=%0d exp=3", target_floor); end
    current_floor = 3'd3;
    tick();
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL up_arrive got=%b exp=1", arrive); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL up_clear got=%h exp=00", pending); end
    n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL up_dwell_tvalid got=%b exp=0", target_valid); end
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL up_dwell_dir got=%b exp=00", direction); end
    n_cmp++; if (target_floor !== 3'd3) begin n_bad++; $display("FAIL up_dwell_target got=%0d exp=3", target_floor); end
    tick();
    n_cmp++; if (arrive !== 1'b0) begin n_bad++; $display("FAIL up_arrive_width got=%b exp=0", arrive); end
    tick();
    tick();
    tick();
    // Dwell over: a call for this floor must now latch rather than be absorbed.
    car_call = 8'h08;
    tick();
    car_call = 8'h00;
    n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL up_idle_after_dwell got=%h exp=08", pending); end
    tick();
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL up_idle_serve_here got=%b exp=1", arrive); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL up_idle_serve_clear got=%h exp=00", pending); end
    $display("test_single_up done");
  endtask

  task automatic test_collection();
    do_reset(3'd1);
    car_call = 8'h40;
    tick();
    car_call = 8'h00;
    tick();
    n_cmp++; if (target_floor !== 3'd6) begin n_bad++; $display("FAIL col_target6 got=%0d exp=6", target_floor); end
    current_floor = 3'd2;
    hall_call = 8'h10;
    tick();
    hall_call = 8'h00;
    n_cmp++; if (pending !== 8'h50) begin n_bad++; $display("FAIL col_pending got=%h exp=50", pending); end
    tick();
    n_cmp++; if (target_floor !== 3'd4) begin n_bad++; $display("FAIL col_target4 got=%0d exp=4", target_floor); end
    n_cmp++; if (direction !== 2'b01) begin n_bad++; $display("FAIL col_dir got=%b exp=01", direction); end
    current_floor = 3'd4;
    tick();
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL col_arrive4 got=%b exp=1", arrive); end
    n_cmp++; if (pending !== 8'h40) begin n_bad++; $display("FAIL col_pending4 got=%h exp=40", pending); end
    tick();
    tick();
    tick();
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL col_dwell_end got=%b exp=00", direction); end
    tick();
    n_cmp++; if (direction !== 2'b01) begin n_bad++; $display("FAIL col_resume_dir got=%b exp=01", direction); end
    n_cmp++; if (target_floor !== 3'd6) begin n_bad++; $display("FAIL col_resume_target got=%0d exp=6", target_floor); end
    current_floor = 3'd6;
    tick();
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL col_arrive6 got=%b exp=1", arrive); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL col_pending6 got=%h exp=00", pending); end
    $display("test_collection done");
  endtask

  task automatic test_reversal();
    do_reset(3'd5);
    car_call = 8'h84;
    tick();
    car_call = 8'h00;
    tick();
    n_cmp++; if (target_floor !== 3'd7) begin n_bad++; $display("FAIL rev_target7 got=%0d exp=7", target_floor); end
    n_cmp++; if (direction !== 2'b01) begin n_bad++; $display("FAIL rev_dir_up got=%b exp=01", direction); end
    current_floor = 3'd6;
    tick();
    current_floor = 3'd7;
    tick();
    n_cmp++; if (pending !== 8'h04) begin n_bad++; $display("FAIL rev_pending got=%h exp=04", pending); end
    tick();
    tick();
    tick();
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL rev_dwell_last got=%b exp=00", direction); end
    tick();
    n_cmp++; if (direction !== 2'b10) begin n_bad++; $display("FAIL rev_dir_down got=%b exp=10", direction); end
    n_cmp++; if (target_floor !== 3'd2) begin n_bad++; $display("FAIL rev_target2 got=%0d exp=2", target_floor); end
    n_cmp++; if (target_valid !== 1'b1) begin n_bad++; $display("FAIL rev_tvalid got=%b exp=1", target_valid); end
    current_floor = 3'd2;
    tick();
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL rev_arrive2 got=%b exp=1", arrive); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rev_pending2 got=%h exp=00", pending); end
    $display("test_reversal done");
  endtask

  task automatic test_tie_dwell();
    do_reset(3'd4);
    car_call = 8'h04;
    hall_call = 8'h40;
    tick();
    car_call = 8'h00;
    hall_call = 8'h00;
    tick();
    n_cmp++; if (direction !== 2'b01) begin n_bad++; $display("FAIL tie_dir got=%b exp=01", direction); end
    n_cmp++; if (target_floor !== 3'd6) begin n_bad++; $display("FAIL tie_target got=%0d exp=6", target_floor); end
    current_floor = 3'd6;
    tick();
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL tie_arrive got=%b exp=1", arrive); end
    tick();
    tick();
    car_call = 8'h40;
    tick();
    car_call = 8'h00;
    n_cmp++; if (pending !== 8'h04) begin n_bad++; $display("FAIL tie_absorb got=%h exp=04", pending); end
    n_cmp++; if (arrive !== 1'b0) begin n_bad++; $display("FAIL tie_no_rearrive got=%b exp=0", arrive); end
    tick();
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL tie_extend1 got=%b exp=00", direction); end
    tick();
    tick();
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL tie_extend3 got=%b exp=00", direction); end
    tick();
    n_cmp++; if (direction !== 2'b10) begin n_bad++; $display("FAIL tie_exit_dir got=%b exp=10", direction); end
    n_cmp++; if (target_floor !== 3'd2) begin n_bad++; $display("FAIL tie_exit_target got=%0d exp=2", target_floor); end
    $display("test_tie_dwell done");
  endtask

  task automatic test_down_and_reset_mid_move();
    do_reset(3'd4);
    car_call = 8'h08;
    hall_call = 8'h80;
    tick();
    car_call = 8'h00;
    hall_call = 8'h00;
    n_cmp++; if (pending !== 8'h88) begin n_bad++; $display("FAIL dn_pending got=%h exp=88", pending); end
    tick();
    n_cmp++; if (direction !== 2'b10) begin n_bad++; $display("FAIL dn_dir got=%b exp=10", direction); end
    n_cmp++; if (target_floor !== 3'd3) begin n_bad++; $display("FAIL dn_target got=%0d exp=3", target_floor); end
    rst = 1'b0;
    #1;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL midrst_pending got=%h exp=00", pending); end
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL midrst_dir got=%b exp=00", direction); end
    n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_tvalid got=%b exp=0", target_valid); end
    n_cmp++; if (target_floor !== 3'd0) begin n_bad++; $display("FAIL midrst_target got=%0d exp=0", target_floor); end
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL midrst_release got=%b exp=00", direction); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL midrst_release_pend got=%h exp=00", pending); end
    $display("test_down_and_reset_mid_move done");
  endtask

  task automatic test_clear_wins();
    do_reset(3'd2);
    car_call = 8'h04;
    tick();
    tick();
    car_call = 8'h00;
    n_cmp++; if (arrive !== 1'b1) begin n_bad++; $display("FAIL clr_arrive got=%b exp=1", arrive); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL clr_wins got=%h exp=00", pending); end
    $display("test_clear_wins done");
  endtask

`ifdef FIRE_RECALL_EN
  task automatic test_fire_recall();
    do_reset(3'd5);
    car_call = 8'h81;
    tick();
    car_call = 8'h00;
    fire_recall = 1'b1;
    tick();
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL fire_pending got=%h exp=00", pending); end
    n_cmp++; if (target_floor !== 3'd0) begin n_bad++; $display("FAIL fire_target got=%0d exp=0", target_floor); end
    n_cmp++; if (direction !== 2'b10) begin n_bad++; $display("FAIL fire_dir got=%b exp=10", direction); end
    current_floor = 3'd0;
    car_call = 8'h20;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL fire_hold_pend cyc%0d got=%h exp=00", i, pending); end
      n_cmp++; if (direction !== 2'b00) begin n_bad++; $display("FAIL fire_hold_dir cyc%0d got=%b exp=00", i, direction); end
    end
    car_call = 8'h00;
    fire_recall = 1'b0;
    tick();
    $display("test_fire_recall done");
  endtask
`endif

  initial begin
    rst = 1'b0;
    car_call = 8'h00;
    hall_call = 8'h00;
    current_floor = 3'd0;
`ifdef FIRE_RECALL_EN
    fire_recall = 1'b0;
`endif
    test_reset();
    test_single_up();
    test_collection();
    test_reversal();
    test_tie_dwell();
    test_down_and_reset_mid_move();
    test_clear_wins();
`ifdef FIRE_RECALL_EN
    test_fire_recall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
